// File: rtl/icache_controller.sv
// icache_controller
//   Direct-mapped instruction-cache controller. It sits in front of a cache
//   set (data RAM + tag/valid RAM with tag compare). It serves CPU fetches on
//   a hit, fetches the word from backing memory and fills the set on a miss,
//   and sequences the invalidate sweep after reset or on flush.
//
// Ports
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_rd, i_addr            CPU fetch request, held until o_ready
//   i_flush                 invalidate the whole cache
//   o_data, o_ready         returned word, one-cycle completion pulse
//   o_busy                  high during the invalidate sweep
//   o_mem_*, i_mem_*        backing-memory read handshake
//   o_set_*, i_set_*        cache-set control; read data/hit lag index by 1 cycle
module icache_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 10,
  parameter int INDEX_WIDTH = 6,
  parameter int ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH + 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_rd,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic                   i_flush,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic                   o_mem_rd,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  input  logic                   i_mem_ack,
  output logic [INDEX_WIDTH-1:0] o_set_index,
  output logic [TAG_WIDTH-1:0]   o_set_tag,
  output logic                   o_set_wr,
  output logic                   o_set_cl,
  output logic [DATA_WIDTH-1:0]  o_set_data,
  input  logic [DATA_WIDTH-1:0]  i_set_data,
  input  logic                   i_set_hit
);

  localparam int LINE_WIDTH = TAG_WIDTH + INDEX_WIDTH;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_FETCH,
    ST_FILL
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;    // {tag, index} of the request in flight
  logic [DATA_WIDTH-1:0]  fill_q, fill_d;

  logic [LINE_WIDTH-1:0]  req_line;
  logic                   unused_addr_bits;

  // Byte-offset bits never select anything: the cache is word-granular.
  assign req_line         = i_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = &{1'b0, i_addr[1:0]};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      flush_pend_q <= 1'b0;
      line_q       <= '0;
      fill_q       <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      flush_pend_q <= flush_pend_d;
      line_q       <= line_d;
      fill_q       <= fill_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    flush_pend_d = flush_pend_q;
    line_d       = line_q;
    fill_d       = fill_q;

    o_data      = '0;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_mem_addr  = '0;
    o_mem_rd    = 1'b0;
    o_set_index = line_q[INDEX_WIDTH-1:0];
    o_set_tag   = line_q[LINE_WIDTH-1:INDEX_WIDTH];
    o_set_wr    = 1'b0;
    o_set_cl    = 1'b0;
    o_set_data  = fill_q;

    // A flush that arrives while busy is remembered and taken at the next IDLE,
    // so the request in flight still completes normally.
    if (i_flush && (state_q != ST_IDLE)) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        o_busy      = 1'b1;
        o_set_cl    = 1'b1;
        o_set_index = sweep_q;
        sweep_d     = sweep_q + 1'b1;
        // Terminal-count exit: the counter wraps to 0 here, so index 0 is
        // not cleared a second time.
        if (sweep_q == {INDEX_WIDTH{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        // Present the incoming address straight away so the set RAM samples
        // index/tag on the same edge that accepts the request.
        o_set_index = req_line[INDEX_WIDTH-1:0];
        o_set_tag   = req_line[LINE_WIDTH-1:INDEX_WIDTH];
        if (i_flush || flush_pend_q) begin
          sweep_d      = '0;
          flush_pend_d = 1'b0;
          state_d      = ST_INIT;
        end else if (i_rd) begin
          line_d  = req_line;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (i_set_hit) begin
          o_ready = 1'b1;
          o_data  = i_set_data;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = {line_q, 2'b00};
        if (i_mem_ack) begin
          fill_d  = i_mem_data;
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        o_set_wr = 1'b1;
        o_ready  = 1'b1;
        o_data   = fill_q;
        state_d  = ST_IDLE;
      end

      default: begin
        sweep_d = '0;
        state_d = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_controller.sv
module tb_icache_controller;

  localparam int DW   = 32;
  localparam int TW   = 10;
  localparam int IW   = 6;
  localparam int AW   = TW + IW + 2;
  localparam int NSET = 1 << IW;

  logic          clk;
  logic          rst;
  logic          i_rd;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic [DW-1:0] o_data;
  logic          o_ready;
  logic          o_busy;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd;
  logic [DW-1:0] i_mem_data;
  logic          i_mem_ack;
  logic [IW-1:0] o_set_index;
  logic [TW-1:0] o_set_tag;
  logic          o_set_wr;
  logic          o_set_cl;
  logic [DW-1:0] o_set_data;
  logic [DW-1:0] i_set_data;
  logic          i_set_hit;

  icache_controller #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_rd(i_rd), .i_addr(i_addr), .i_flush(i_flush),
    .o_data(o_data), .o_ready(o_ready), .o_busy(o_busy),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .i_mem_data(i_mem_data), .i_mem_ack(i_mem_ack),
    .o_set_index(o_set_index), .o_set_tag(o_set_tag), .o_set_wr(o_set_wr), .o_set_cl(o_set_cl),
    .o_set_data(o_set_data), .i_set_data(i_set_data), .i_set_hit(i_set_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            hit;
    int            issue;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   fixed_delay = -1;
  bit   hold_ack = 0;
  bit   force_ack = 0;

  // reference cache contents (valid + tag per line)
  bit            m_v[NSET];
  logic [TW-1:0] m_t[NSET];

  // cache-set RAM environment
  bit            set_v[NSET];
  logic [TW-1:0] set_t[NSET];
  logic [DW-1:0] set_d[NSET];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = {a[AW-1:2], 2'b00};
    if (w == 18'h00104) return 32'hDEADBEEF;
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NSET; k++) m_v[k] = 0;
  endfunction

  // Set RAM: index/tag sampled on the clock edge, read data and hit one cycle later.
  initial begin
    logic [IW-1:0] s_idx;
    logic [TW-1:0] s_tag;
    logic [DW-1:0] s_wdata;
    bit            s_wr, s_cl;
    for (int k = 0; k < NSET; k++) begin
      set_v[k] = 1'($urandom_range(0, 1));
      set_t[k] = TW'($urandom);
      set_d[k] = $urandom;
    end
    i_set_hit  <= 1'b0;
    i_set_data <= '0;
    forever begin
      @(negedge clk);
      #2;
      s_idx = o_set_index; s_tag = o_set_tag; s_wr = o_set_wr; s_cl = o_set_cl; s_wdata = o_set_data;
      @(posedge clk);
      i_set_hit  <= !s_wr && !s_cl && set_v[s_idx] && (set_t[s_idx] == s_tag);
      i_set_data <= set_d[s_idx];
      if (s_cl) set_v[s_idx] = 0;
      if (s_wr) begin
        set_v[s_idx] = 1;
        set_t[s_idx] = s_tag;
        set_d[s_idx] = s_wdata;
      end
    end
  end

  // Backing memory: acks after 0..3 extra cycles (or a fixed delay).
  initial begin
    int left = 0;
    bit in_req = 0;
    i_mem_ack  = 1'b0;
    i_mem_data = '0;
    forever begin
      @(negedge clk);
      i_mem_ack  = 1'b0;
      i_mem_data = '0;
      if (force_ack) begin
        i_mem_ack  = 1'b1;
        i_mem_data = 32'h0BADF00D;
        force_ack  = 0;
      end else if (o_mem_rd && !hold_ack) begin
        if (!in_req) begin
          in_req = 1;
          left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
        if (left == 0) begin
          i_mem_ack  = 1'b1;
          i_mem_data = mem_word(o_mem_addr);
          in_req     = 0;
        end else begin
          left--;
        end
      end else begin
        in_req = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit   fetched = 0;
    bit   in_sweep = 1;
    int   sw_cnt = 0;
    int   ack_cyc = -100;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        fetched  = 0;
        in_sweep = 1;
        sw_cnt   = 0;
      end else begin
        if (!o_ready) chk("data_zero_when_not_ready", o_data, 0);
        chk("wr_cl_exclusive", o_set_wr & o_set_cl, 0);
        if (o_busy) begin
          if (!in_sweep) begin
            in_sweep = 1;
            sw_cnt   = 0;
          end
          chk("sweep_cl", o_set_cl, 1);
          chk("sweep_index", o_set_index, sw_cnt);
          sw_cnt++;
        end else if (in_sweep) begin
          chk("sweep_length", sw_cnt, NSET);
          in_sweep = 0;
        end
        if (o_mem_rd && !fetched) begin
          fetched = 1;
          chk("mem_rd_queue_depth", sb.size(), 1);
          if (sb.size() > 0) chk("mem_addr", o_mem_addr, {sb[0].addr[AW-1:2], 2'b00});
        end
        if (o_mem_rd && i_mem_ack) ack_cyc = cyc;
        if (o_set_wr) begin
          chk("set_wr_queue_depth", sb.size(), 1);
          if (sb.size() > 0) begin
            chk("fill_index", o_set_index, sb[0].addr[IW+1:2]);
            chk("fill_tag", o_set_tag, sb[0].addr[AW-1:IW+2]);
            chk("fill_data", o_set_data, sb[0].data);
          end
        end
        if (o_ready) begin
          chk("ready_queue_depth", sb.size(), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("read_data", o_data, e.data);
            chk("went_to_memory", fetched, !e.hit);
            if (e.hit) chk("hit_latency", cyc - e.issue, 1);
            else       chk("miss_latency", cyc - ack_cyc, 1);
            $display("read addr=0x%05h data=0x%08h %s", e.addr, o_data, e.hit ? "hit" : "miss");
          end
          fetched = 0;
        end
      end
    end
  end

  task automatic push_req(input logic [AW-1:0] a);
    exp_t e;
    logic [IW-1:0] ix;
    logic [TW-1:0] tg;
    ix = a[IW+1:2];
    tg = a[AW-1:IW+2];
    e.addr  = a;
    e.data  = mem_word(a);
    e.hit   = m_v[ix] && (m_t[ix] == tg);
    e.issue = cyc;
    sb.push_back(e);
    m_v[ix] = 1;
    m_t[ix] = tg;
  endtask

  task automatic wait_ready(input int limit);
    bit got = 0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      if (i_flush) i_flush = 1'b0;
      if (o_ready) got = 1;
    end
    chk("ready_seen", got, 1);
    i_rd = 1'b0;
  endtask

  task automatic wait_sweep();
    bit seen = 0;
    bit done = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_busy) seen = 1;
    end
    for (int k = 0; k < 100 && seen && !done; k++) begin
      @(negedge clk);
      if (!o_busy) done = 1;
    end
    chk("sweep_completed", done, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly, input bit flush_mid);
    bit got = 0;
    bit flushed = 0;
    fixed_delay = dly;
    @(negedge clk);
    push_req(a);
    i_rd   = 1'b1;
    i_addr = a;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (i_flush) i_flush = 1'b0;
      if (o_ready) got = 1;
      else if (flush_mid && o_mem_rd && !flushed) begin
        i_flush = 1'b1;
        flushed = 1;
      end
    end
    chk("ready_seen", got, 1);
    i_rd = 1'b0;
    if (flush_mid) begin
      model_clear();
      wait_sweep();
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    i_flush = 1'b1;
    model_clear();
    @(negedge clk);
    i_flush = 1'b0;
    wait_sweep();
  endtask

  task automatic do_flush_read(input logic [AW-1:0] a);
    fixed_delay = -1;
    @(negedge clk);
    model_clear();
    push_req(a);
    i_flush = 1'b1;
    i_rd    = 1'b1;
    i_addr  = a;
    wait_ready(300);
  endtask

  task automatic check_reset_outputs();
    #1;
    chk("rst_busy", o_busy, 1);
    chk("rst_set_cl", o_set_cl, 1);
    chk("rst_set_index", o_set_index, 0);
    chk("rst_set_wr", o_set_wr, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_data", o_data, 0);
    chk("rst_mem_rd", o_mem_rd, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    bit seen_rd;
    rst     = 1'b1;
    i_rd    = 1'b0;
    i_addr  = '0;
    i_flush = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    wait_sweep();

    // directed: cold misses, hit, conflict eviction
    do_read(18'h00100, -1, 0);
    do_read(18'h00104, 3, 0);
    do_read(18'h00104, 3, 0);
    do_read(18'h10104, 0, 0);
    do_read(18'h00104, 1, 0);
    do_read(18'h00104, 1, 0);

    // flush together with a read: sweep first, then a miss
    do_flush_read(18'h00104);
    do_read(18'h00104, -1, 0);

    // flush while the miss is in FETCH
    do_read(18'h00208, 3, 1);
    do_read(18'h00208, 0, 0);

    // randomized traffic over a small address pool
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 24) == 0) do_flush();
      a = {TW'($urandom_range(0, 3)), IW'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_read(a, -1, 0);
    end

    // reset while the memory read is outstanding
    hold_ack = 1;
    @(negedge clk);
    push_req(18'h3FFFC);
    i_rd   = 1'b1;
    i_addr = 18'h3FFFC;
    seen_rd = 0;
    for (int k = 0; k < 20 && !seen_rd; k++) begin
      @(negedge clk);
      if (o_mem_rd) seen_rd = 1;
    end
    chk("mem_rd_before_reset", seen_rd, 1);
    rst = 1'b1;
    sb.delete();
    model_clear();
    i_rd = 1'b0;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    force_ack = 1;
    wait_sweep();
    hold_ack = 0;
    do_read(18'h3FFFC, -1, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
